gate_truth_table_sequencer: RTL and testbench

GATE_TRUTH_TABLE_SEQUENCER -- requirements
Module: gate_truth_table_sequencer

---
 rtl/gate_truth_table_sequencer.sv | 136 +++++++++++++
 tb/tb_gate_truth_table_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_table_sequencer.sv
// Gate truth-table sequencer: drives the four operand vectors into an
// 8-function gate unit, captures each result and compares it against the
// known-good truth table. All outputs are registered.
module gate_truth_table_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1  // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  gate_res,
    output logic        gate_a,
    output logic        gate_b,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  fail_mask,
    output logic [31:0] table_out
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StDrive  = 2'd1;
    localparam logic [1:0] StSample = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    // Expected results, vector v in bits [8v+7:8v]
    localparam logic [31:0] ExpTable   = 32'h835A56BC;
    localparam logic [3:0]  SettleLast = 4'(SETTLE_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  vec_q, vec_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gate_a_d, gate_b_d;
    logic        busy_d, done_d, pass_d;
    logic [3:0]  fail_mask_d;
    logic [31:0] table_out_d;
    logic [4:0]  lane;

    assign lane = {vec_q, 3'b000};

    // Next-state, capture/compare and registered-output decode
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        pass_d      = pass;
        fail_mask_d = fail_mask;
        table_out_d = table_out;

        case (state_q)
            StIdle: begin
                // abort beats start
                if (start && !abort) begin
                    state_d     = StDrive;
                    vec_d       = 2'd0;
                    cnt_d       = 4'd0;
                    fail_mask_d = 4'b0;
                    table_out_d = 32'b0;
                    pass_d      = 1'b0;
                end
            end
            StDrive: begin
                if (abort) begin
                    state_d = StIdle;
                    vec_d   = 2'd0;
                    cnt_d   = 4'd0;
                    pass_d  = 1'b0;
                end else if (cnt_q == SettleLast) begin
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StSample: begin
                // Capture happens even when aborting so partial results survive
                table_out_d[lane +: 8] = gate_res;
                if (gate_res != ExpTable[lane +: 8]) begin
                    fail_mask_d[vec_q] = 1'b1;
                end
                if (abort) begin
                    state_d = StIdle;
                    vec_d   = 2'd0;
                    cnt_d   = 4'd0;
                    pass_d  = 1'b0;
                end else if (vec_q == 2'd3) begin
                    state_d = StDone;
                    vec_d   = 2'd0;
                    cnt_d   = 4'd0;
                    done_d  = 1'b1;
                    pass_d  = (fail_mask_d == 4'b0);
                end else begin
                    state_d = StDrive;
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                // StDone: abort has no effect here
                state_d = StIdle;
            end
        endcase

        busy_d   = (state_d == StDrive) || (state_d == StSample);
        gate_a_d = busy_d & vec_d[1];
        gate_b_d = busy_d & vec_d[0];
    end

    // State and registered outputs, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            vec_q     <= 2'd0;
            cnt_q     <= 4'd0;
            gate_a    <= 1'b0;
            gate_b    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= 4'b0;
            table_out <= 32'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            gate_a    <= gate_a_d;
            gate_b    <= gate_b_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            fail_mask <= fail_mask_d;
            table_out <= table_out_d;
        end
    end

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// Bench for gate_truth_table_sequencer: two instances (settle 1 and 3) driven
// by shared start/abort/reset, each against a gate model with injectable
// faults, checked every cycle against a run-time based reference model.
module tb_gate_truth_table_sequencer;

    localparam int S0 = 1;
    localparam int S1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        abort;
    logic [1:0]  ga, gb, busy, done, pass;
    logic [3:0]  fm  [2];
    logic [31:0] tbl [2];
    logic [7:0]  res [2];
    logic [7:0]  fmask [2][4];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_run  [2];
    bit          m_done [2];
    bit          m_pass [2];
    int          m_k    [2];
    logic [3:0]  m_mask [2];
    logic [31:0] m_tbl  [2];

    function automatic logic [7:0] golden(input logic [1:0] v);
        logic a, b;
        a = v[1];
        b = v[0];
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~b, ~a, a | b, a & b};
    endfunction

    assign res[0] = golden({ga[0], gb[0]}) ^ fmask[0][{ga[0], gb[0]}];
    assign res[1] = golden({ga[1], gb[1]}) ^ fmask[1][{ga[1], gb[1]}];

    gate_truth_table_sequencer #(.SETTLE_CYCLES(S0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_res(res[0]),
        .gate_a(ga[0]), .gate_b(gb[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .fail_mask(fm[0]), .table_out(tbl[0])
    );

    gate_truth_table_sequencer #(.SETTLE_CYCLES(S1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_res(res[1]),
        .gate_a(ga[1]), .gate_b(gb[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .fail_mask(fm[1]), .table_out(tbl[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int per_of(input int i);
        return ((i == 0) ? S0 : S1) + 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i]  = 0;
            m_done[i] = 0;
            m_pass[i] = 0;
            m_k[i]    = 0;
            m_mask[i] = 4'b0;
            m_tbl[i]  = 32'b0;
        end
    endtask

    // One rising edge of the run: vector v occupies cycles (S+1)*v+1 .. (S+1)*(v+1)
    // after the accepting edge; the last of those is where the result is taken.
    task automatic model_step(input int i, input bit st, input bit ab);
        int per, v;
        logic [7:0] r;
        per = per_of(i);
        if (m_done[i]) begin
            m_done[i] = 0;
        end else if (m_run[i]) begin
            m_k[i]++;
            if (m_k[i] % per == 0) begin
                v = (m_k[i] - 1) / per;
                r = golden(2'(v)) ^ fmask[i][v];
                m_tbl[i][8*v +: 8] = r;
                if (fmask[i][v] != 8'h00) m_mask[i][v] = 1'b1;
            end
            if (ab) begin
                m_run[i]  = 0;
                m_pass[i] = 0;
            end else if (m_k[i] == 4 * per) begin
                m_run[i]  = 0;
                m_done[i] = 1;
                m_pass[i] = (m_mask[i] == 4'b0);
            end
        end else if (st && !ab) begin
            m_run[i]  = 1;
            m_k[i]    = 0;
            m_mask[i] = 4'b0;
            m_tbl[i]  = 32'b0;
            m_pass[i] = 0;
        end
    endtask

    task automatic check_all();
        int v;
        logic [1:0] g;
        for (int i = 0; i < 2; i++) begin
            v = m_k[i] / per_of(i);
            g = m_run[i] ? 2'(v) : 2'b00;
            check($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_run[i]));
            check($sformatf("done%0d", i), 32'(done[i]), 32'(m_done[i]));
            check($sformatf("pass%0d", i), 32'(pass[i]), 32'(m_pass[i]));
            check($sformatf("gate_ab%0d", i), 32'({ga[i], gb[i]}), 32'(g));
            check($sformatf("fail_mask%0d", i), 32'(fm[i]), 32'(m_mask[i]));
            check($sformatf("table_out%0d", i), tbl[i], m_tbl[i]);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic cycle(input bit st, input bit ab);
        start = st;
        abort = ab;
        @(posedge clk);
        if (rst_n) begin
            model_step(0, st, ab);
            model_step(1, st, ab);
        end
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_run[0] || m_run[1] || m_done[0] || m_done[1]) && n < 60) begin
            cycle(0, 0);
            n++;
        end
        if (n >= 60) check("drain_timeout", 32'(n), 32'd0);
    endtask

    task automatic set_faults(input logic [7:0] keep);
        for (int i = 0; i < 2; i++)
            for (int v = 0; v < 4; v++)
                fmask[i][v] = golden(2'(v)) & keep;
    endtask

    // Start one run on both instances, measure both latencies
    task automatic run_both(output int l0, output int l1);
        l0 = -1;
        l1 = -1;
        cycle(1, 0);
        for (int k = 1; k <= 40 && (l0 < 0 || l1 < 0); k++) begin
            cycle(0, 0);
            if (done[0] && l0 < 0) l0 = k;
            if (done[1] && l1 < 0) l1 = k;
        end
    endtask

    initial begin
        int l0, l1, nd, t[3];
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        set_faults(8'h00);
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Clean run; start accepted on first edge after reset release
        run_both(l0, l1);
        check("latency_s1", 32'(l0), 32'd8);
        check("latency_s3", 32'(l1), 32'd16);
        check("clean_table", tbl[0], 32'h835A56BC);
        check("clean_pass", 32'(pass[0]), 32'd1);
        check("clean_mask", 32'(fm[0]), 32'd0);
        drain();

        // xor output stuck at 0
        set_faults(8'h40);
        run_both(l0, l1);
        check("xor0_mask", 32'(fm[0]), 32'b0110);
        check("xor0_table", tbl[0], 32'h831A16BC);
        check("xor0_pass", 32'(pass[0]), 32'd0);
        drain();
        set_faults(8'h00);

        // Abort during sample of v=1 (settle 1)
        cycle(1, 0);
        for (int k = 0; k < 3; k++) cycle(0, 0);
        cycle(0, 1);
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_lo_table", 32'(tbl[0][15:0]), 32'h56BC);
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(0, 0);
            nd += int'(done[0]);
        end
        check("abort_no_done", 32'(nd), 32'd0);

        // Reset during v=2, then a clean run straight after release
        cycle(1, 0);
        for (int k = 0; k < 5; k++) cycle(0, 0);
        pulse_reset();
        run_both(l0, l1);
        check("post_reset_latency", 32'(l0), 32'd8);
        check("post_reset_pass", 32'(pass[0]), 32'd1);
        drain();

        // start held high for 30 cycles
        nd = 0;
        for (int k = 1; k <= 30; k++) begin
            cycle(1, 0);
            if (done[0]) begin
                if (nd < 3) t[nd] = k;
                nd++;
            end
        end
        check("held_done_count", 32'(nd), 32'd3);
        if (nd >= 3) begin
            check("held_spacing0", 32'(t[1] - t[0]), 32'd10);
            check("held_spacing1", 32'(t[2] - t[1]), 32'd10);
        end
        drain();

        // Randomized traffic with random faults, aborts and resets
        for (int k = 0; k < 1500; k++) begin
            if (!m_run[0] && !m_run[1] && !m_done[0] && !m_done[1]
                && $urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 2; i++)
                    for (int v = 0; v < 4; v++)
                        fmask[i][v] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            end
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset();
            end else begin
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
